// File: rtl/alarm_sound_controller_pkg.sv
// alarm_sound_controller_pkg
// Shared definitions for the alarm sound controller slice.
// Contents: BCD digit width, minute-counter width, snooze-count width,
// FSM state encoding and a helper that compares two clock readings.
package alarm_sound_controller_pkg;

    localparam int DIGIT_W = 4;
    localparam int CNT_W   = 4;
    localparam int LEFT_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_t;

    // The alarm matches only when every digit and the AM/PM flag agree.
    function automatic logic bcd_time_equal(
        input logic [DIGIT_W-1:0] a_ms_hr,
        input logic [DIGIT_W-1:0] a_ls_hr,
        input logic [DIGIT_W-1:0] a_ms_min,
        input logic [DIGIT_W-1:0] a_ls_min,
        input logic               a_am,
        input logic [DIGIT_W-1:0] b_ms_hr,
        input logic [DIGIT_W-1:0] b_ls_hr,
        input logic [DIGIT_W-1:0] b_ms_min,
        input logic [DIGIT_W-1:0] b_ls_min,
        input logic               b_am
    );
        return (a_ms_hr == b_ms_hr) && (a_ls_hr == b_ls_hr) &&
               (a_ms_min == b_ms_min) && (a_ls_min == b_ls_min) &&
               (a_am == b_am);
    endfunction

endpackage

// File: rtl/alarm_sound_controller_if.sv
// alarm_sound_controller_if
// Bundles the time-of-day, stored alarm time, button pulses and alarm
// indicator outputs of the alarm sound controller.
// Modports:
//   master - upstream/testbench side: drives time, alarm, buttons, enable;
//            observes sound_alarm, snooze_active, snoozes_left
//   slave  - controller side: the reverse directions
interface alarm_sound_controller_if;
    import alarm_sound_controller_pkg::*;

    logic                one_minute;
    logic                alarm_enable;
    logic                snooze_button;
    logic                stop_button;
    logic [DIGIT_W-1:0]  current_time_ms_hr;
    logic [DIGIT_W-1:0]  current_time_ls_hr;
    logic [DIGIT_W-1:0]  current_time_ms_min;
    logic [DIGIT_W-1:0]  current_time_ls_min;
    logic                current_time_am;
    logic [DIGIT_W-1:0]  current_alarm_ms_hr;
    logic [DIGIT_W-1:0]  current_alarm_ls_hr;
    logic [DIGIT_W-1:0]  current_alarm_ms_min;
    logic [DIGIT_W-1:0]  current_alarm_ls_min;
    logic                current_alarm_am;
    logic                sound_alarm;
    logic                snooze_active;
    logic [LEFT_W-1:0]   snoozes_left;

    modport master (
        output one_minute, alarm_enable, snooze_button, stop_button,
        output current_time_ms_hr, current_time_ls_hr,
        output current_time_ms_min, current_time_ls_min, current_time_am,
        output current_alarm_ms_hr, current_alarm_ls_hr,
        output current_alarm_ms_min, current_alarm_ls_min, current_alarm_am,
        input  sound_alarm, snooze_active, snoozes_left
    );

    modport slave (
        input  one_minute, alarm_enable, snooze_button, stop_button,
        input  current_time_ms_hr, current_time_ls_hr,
        input  current_time_ms_min, current_time_ls_min, current_time_am,
        input  current_alarm_ms_hr, current_alarm_ls_hr,
        input  current_alarm_ms_min, current_alarm_ls_min, current_alarm_am,
        output sound_alarm, snooze_active, snoozes_left
    );

endinterface

// File: rtl/alarm_minute_counter.sv
// alarm_minute_counter
// Loadable 4-bit down-counter advanced by the one_minute pulse. It holds at
// zero rather than wrapping.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   load          - load load_value this edge (wins over tick)
//   load_value    - value to load
//   tick          - one_minute pulse, decrements when count is non-zero
//   count         - current count
//   zero          - count is zero
module alarm_minute_counter
    import alarm_sound_controller_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clock) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (tick && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alarm_sound_controller.sv
// alarm_sound_controller
// Rings when the time of day enters the stored alarm minute, supports a
// limited number of snoozes, a stop button, and silences itself after
// RING_MINUTES minutes of ringing.
// Ports:
//   clock, reset - rising-edge clock, synchronous active-high reset
//   bus          - slave side of alarm_sound_controller_if (time digits,
//                  alarm digits, buttons, enable in; sound_alarm,
//                  snooze_active, snoozes_left out, all registered)
module alarm_sound_controller
    import alarm_sound_controller_pkg::*;
#(
    parameter int unsigned RING_MINUTES   = 5,
    parameter int unsigned SNOOZE_MINUTES = 9,
    parameter int unsigned MAX_SNOOZES    = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    alarm_sound_controller_if.slave   bus
);

    localparam logic [CNT_W-1:0]  RING_LOAD   = CNT_W'(RING_MINUTES);
    localparam logic [CNT_W-1:0]  SNOOZE_LOAD = CNT_W'(SNOOZE_MINUTES);
    localparam logic [LEFT_W-1:0] SNOOZE_MAX  = LEFT_W'(MAX_SNOOZES);

    alarm_state_t        state, state_next;
    logic                match, match_q, trigger, expire;
    logic                load;
    logic [CNT_W-1:0]    load_value, count;
    logic                count_zero;
    logic [LEFT_W-1:0]   snoozes_left_q, snoozes_next;
    logic                sound_q, snooze_q;

    assign match = bcd_time_equal(
        bus.current_time_ms_hr,  bus.current_time_ls_hr,
        bus.current_time_ms_min, bus.current_time_ls_min, bus.current_time_am,
        bus.current_alarm_ms_hr,  bus.current_alarm_ls_hr,
        bus.current_alarm_ms_min, bus.current_alarm_ls_min, bus.current_alarm_am);

    // match_q resets high so a match already present at reset release is
    // not seen as entering the alarm minute.
    assign trigger = match && !match_q && bus.alarm_enable;

    // The period ends on the pulse that takes the count from 1 to 0.
    assign expire = bus.one_minute && (count_zero || (count == CNT_W'(1)));

    alarm_minute_counter u_minute_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .tick       (bus.one_minute),
        .count      (count),
        .zero       (count_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            match_q        <= 1'b1;
            snoozes_left_q <= SNOOZE_MAX;
            sound_q        <= 1'b0;
            snooze_q       <= 1'b0;
        end else begin
            state          <= state_next;
            match_q        <= match;
            snoozes_left_q <= snoozes_next;
            sound_q        <= (state_next == RINGING);
            snooze_q       <= (state_next == SNOOZE);
        end
    end

    // Disable beats stop, stop beats snooze, snooze beats expiry. A snooze
    // with none left falls through so expiry can still end the ringing.
    always_comb begin
        state_next   = state;
        load         = 1'b0;
        load_value   = RING_LOAD;
        snoozes_next = snoozes_left_q;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_next   = RINGING;
                    load         = 1'b1;
                    load_value   = RING_LOAD;
                    snoozes_next = SNOOZE_MAX;
                end
            end
            RINGING: begin
                if (!bus.alarm_enable || bus.stop_button) begin
                    state_next = IDLE;
                end else if (bus.snooze_button && (snoozes_left_q != '0)) begin
                    state_next   = SNOOZE;
                    load         = 1'b1;
                    load_value   = SNOOZE_LOAD;
                    snoozes_next = snoozes_left_q - 1'b1;
                end else if (expire) begin
                    state_next = IDLE;
                end
            end
            SNOOZE: begin
                if (!bus.alarm_enable || bus.stop_button) begin
                    state_next = IDLE;
                end else if (expire) begin
                    state_next = RINGING;
                    load       = 1'b1;
                    load_value = RING_LOAD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.sound_alarm   = sound_q;
    assign bus.snooze_active = snooze_q;
    assign bus.snoozes_left  = snoozes_left_q;

endmodule

// File: tb/tb_alarm_sound_controller.sv
// tb_alarm_sound_controller
// Directed self-checking bench for alarm_sound_controller with default
// parameters (ring 5 minutes, snooze 9 minutes, 3 snoozes).
module tb_alarm_sound_controller;
    import alarm_sound_controller_pkg::*;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    alarm_sound_controller_if bus ();

    alarm_sound_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic setTime(input logic [3:0] mh, input logic [3:0] lh,
                           input logic [3:0] mm, input logic [3:0] lm,
                           input logic am);
        bus.current_time_ms_hr  = mh;
        bus.current_time_ls_hr  = lh;
        bus.current_time_ms_min = mm;
        bus.current_time_ls_min = lm;
        bus.current_time_am     = am;
    endtask

    task automatic setAlarm(input logic [3:0] mh, input logic [3:0] lh,
                            input logic [3:0] mm, input logic [3:0] lm,
                            input logic am);
        bus.current_alarm_ms_hr  = mh;
        bus.current_alarm_ls_hr  = lh;
        bus.current_alarm_ms_min = mm;
        bus.current_alarm_ls_min = lm;
        bus.current_alarm_am     = am;
    endtask

    // Holds the given pulses across exactly one rising edge, then settles
    // 1 unit past the edge so outputs are sampled away from it.
    task automatic applyStimulus(input logic minute, input logic snooze,
                                 input logic stop);
        bus.one_minute    = minute;
        bus.snooze_button = snooze;
        bus.stop_button   = stop;
        @(posedge clock);
        #1;
        bus.one_minute    = 1'b0;
        bus.snooze_button = 1'b0;
        bus.stop_button   = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic exp_sound,
                               input logic exp_snooze, input logic [2:0] exp_left);
        vectors++;
        assert (bus.sound_alarm === exp_sound) else begin
            miscompares++;
            $error("[TB] FAIL %s sound_alarm observed=%b expected=%b", tag, bus.sound_alarm, exp_sound);
        end
        vectors++;
        assert (bus.snooze_active === exp_snooze) else begin
            miscompares++;
            $error("[TB] FAIL %s snooze_active observed=%b expected=%b", tag, bus.snooze_active, exp_snooze);
        end
        vectors++;
        assert (bus.snoozes_left === exp_left) else begin
            miscompares++;
            $error("[TB] FAIL %s snoozes_left observed=%0d expected=%0d", tag, bus.snoozes_left, exp_left);
        end
    endtask

    // Moves the time off the alarm minute and back, producing a fresh match edge.
    task automatic reenterMinute(input logic [3:0] lm_away, input logic [3:0] lm_alarm);
        bus.current_time_ls_min = lm_away;
        applyStimulus(1'b0, 1'b0, 1'b0);
        bus.current_time_ls_min = lm_alarm;
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.alarm_enable  = 1'b1;
        bus.one_minute    = 1'b0;
        bus.snooze_button = 1'b0;
        bus.stop_button   = 1'b0;
        setTime (4'd0, 4'd7, 4'd3, 4'd0, 1'b1);
        setAlarm(4'd0, 4'd7, 4'd3, 4'd0, 1'b1);

        // Test 1: match present through reset release must not ring.
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reset_state", 1'b0, 1'b0, 3'd3);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("no_ring_after_reset", 1'b0, 1'b0, 3'd3);
        bus.current_time_ls_min = 4'd1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("time_0731", 1'b0, 1'b0, 3'd3);
        bus.current_time_ls_min = 4'd0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ring_on_match_rise", 1'b1, 1'b0, 3'd3);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stop_t1", 1'b0, 1'b0, 3'd3);

        // Test 2: 06:45 PM rings for exactly five minute pulses.
        setTime (4'd0, 4'd6, 4'd4, 4'd4, 1'b0);
        setAlarm(4'd0, 4'd6, 4'd4, 4'd5, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        bus.current_time_ls_min = 4'd5;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ring_0645pm", 1'b1, 1'b0, 3'd3);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("ring_after_4_min", 1'b1, 1'b0, 3'd3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("timeout_5th_min", 1'b0, 1'b0, 3'd3);

        // Test 3: three snoozes honoured, the fourth ignored.
        reenterMinute(4'd6, 4'd5);
        checkOutput("ring_t3", 1'b1, 1'b0, 3'd3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("snooze1", 1'b0, 1'b1, 3'd2);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("snooze1_after_8", 1'b0, 1'b1, 3'd2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rering1", 1'b1, 1'b0, 3'd2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("snooze2", 1'b0, 1'b1, 3'd1);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rering2", 1'b1, 1'b0, 3'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("snooze3", 1'b0, 1'b1, 3'd0);
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rering3", 1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("snooze4_ignored", 1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stop_t3", 1'b0, 1'b0, 3'd0);

        // Test 4: stop beats snooze; stop during snooze.
        reenterMinute(4'd6, 4'd5);
        checkOutput("ring_t4a", 1'b1, 1'b0, 3'd3);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("stop_and_snooze", 1'b0, 1'b0, 3'd3);
        reenterMinute(4'd6, 4'd5);
        checkOutput("ring_t4b", 1'b1, 1'b0, 3'd3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("snooze_t4", 1'b0, 1'b1, 3'd2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stop_in_snooze", 1'b0, 1'b0, 3'd2);

        // AM/PM flag alone breaks the match.
        bus.current_time_am = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("am_mismatch", 1'b0, 1'b0, 3'd2);
        bus.current_time_am = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("pm_match_rings", 1'b1, 1'b0, 3'd3);
        applyStimulus(1'b0, 1'b0, 1'b1);

        // Test 5: enable handling.
        bus.alarm_enable = 1'b0;
        reenterMinute(4'd6, 4'd5);
        checkOutput("disabled_no_ring", 1'b0, 1'b0, 3'd3);
        bus.alarm_enable = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("enable_late_no_ring", 1'b0, 1'b0, 3'd3);
        reenterMinute(4'd6, 4'd5);
        checkOutput("ring_t5", 1'b1, 1'b0, 3'd3);
        bus.alarm_enable = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("disable_mid_ring", 1'b0, 1'b0, 3'd3);
        bus.alarm_enable = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reenable_no_rering", 1'b0, 1'b0, 3'd3);

        // Test 6: reset mid-snooze, then an alarm load equal to now rings.
        reenterMinute(4'd6, 4'd5);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("snooze_t6", 1'b0, 1'b1, 3'd2);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reset_mid_snooze", 1'b0, 1'b0, 3'd3);
        reset = 1'b0;
        setAlarm(4'd0, 4'd7, 4'd0, 4'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("alarm_elsewhere", 1'b0, 1'b0, 3'd3);
        setAlarm(4'd0, 4'd6, 4'd4, 4'd5, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("load_alarm_eq_now", 1'b1, 1'b0, 3'd3);
        setAlarm(4'd0, 4'd8, 4'd0, 4'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reload_keeps_ringing", 1'b1, 1'b0, 3'd3);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("stop_t6", 1'b0, 1'b0, 3'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
